bus_pipeline_slice: RTL
=======================

// Module: bus_pipeline_slice
// PURPOSE
//  Buffered register slice for the OCP-style Bus between one master and one slave. Decouples timing on both request and response paths with parametrised FIFOs.
//  Limits outstanding transactions and flags protocol violations.
//  Sits between a bus master's Bus_if.master port and a slave's Bus_if.slave port.
//  Adds byte-enable support and split request/response buffering that a plain bus connection lacks.
// PARAMETERS
//  ADDR_WIDTH      32  address width
//  DATA_WIDTH      32  data width; multiple of 8; NB = DATA_WIDTH/8
//  REQ_DEPTH       2   request FIFO entries; power of 2, >=2
//  RESP_DEPTH      2   response FIFO entries; power of 2, >=2
//  MAX_OUTSTANDING 4   max accepted-but-unanswered requests; 1..255
//  WRITERESP_EN    1   1: writes get a response and count as outstanding; 0: writes are posted
//  BYTEEN_EN       0   1: forward MByteEn; 0: m_MByteEn is tied to all-ones
// PORTS
//  Clk            in   1     clock, all logic on posedge
//  MReset_n       in   1     async active-low reset
//  s_MAddr        in   ADDR  upstream request address
//  s_MCmd         in   3     upstream Bus::Ocp_cmd (IDLE/WR/RD)
//  s_MData        in   DATA  upstream write data
//  s_MByteEn      in   NB    upstream byte enables
//  s_SCmdAccept   out  1     upstream request accepted
//  s_SResp        out  2     upstream Bus::Ocp_resp (NULL/DVA/ERR)
//  s_SData        out  DATA  upstream read data
//  s_MRespAccept  in   1     upstream master takes response
//  m_MReset_n     out  1     = MReset_n, combinational pass-through
//  m_MAddr/m_MCmd/m_MData/m_MByteEn  out  as s_*  downstream request (FIFO head)
//  m_SCmdAccept   in   1     downstream slave accepts request
//  m_SResp        in   2     downstream response
//  m_SData        in   DATA  downstream read data
//  m_MRespAccept  out  1     slice takes downstream response
//  outstanding    out  8     current outstanding count
//  err_unexp_resp out  1     sticky: response arrived with none pending
// BEHAVIOUR
//  Reset (async, MReset_n=0): both FIFOs empty; counters 0; err_unexp_resp=0.
//   Outputs during reset: m_MCmd=IDLE, s_SResp=NULL, s_SCmdAccept=0, m_MRespAccept=0, m_MAddr/m_MData/s_SData=0.
//   Reset mid-transfer discards all buffered requests and responses; no replay.
//  Request path:
//   s_SCmdAccept = !req_full && (outstanding_cnt < MAX_OUTSTANDING).
//   Accept fires when s_MCmd!=IDLE && s_SCmdAccept; {addr,cmd,data,byteen} is pushed.
//   s_SCmdAccept depends on registered state only; a same-cycle pop never frees space for a same-cycle push.
//   Head is driven on m_* whenever req FIFO is non-empty, else m_MCmd=IDLE.
//   Head is held stable until m_SCmdAccept, then popped.
//   Latency: accept in cycle N -> visible on m_MCmd in cycle N+1 (empty FIFO).
//  Response path:
//   m_MRespAccept = !resp_full.
//   Push when m_SResp!=NULL && m_MRespAccept.
//   s_SResp/s_SData = head (NULL when empty), held stable until s_MRespAccept, then popped. Latency 1 cycle.
//  Outstanding count:
//   +1 on upstream accept of RD, or WR when WRITERESP_EN=1.
//   -1 on upstream response pop. Simultaneous +1 and -1 leaves the count unchanged.
//   WRITERESP_EN=0: WR is forwarded and never counted; any downstream response to a write is a violation.
//  Downstream pending count: +1 on counted downstream request accept, -1 on response push.
//   Response push with pending=0 sets err_unexp_resp (sticky until reset).
//   That response is still buffered; pending saturates at 0.
//  Ordering: strict in-order on both paths; no reordering or merging.
//  BYTEEN_EN=0: m_MByteEn='1 regardless of s_MByteEn.
// TESTING
//  Single RD, slave accepts immediately -> m_MCmd=RD 1 cycle after accept; DVA/0xCAFE reaches s_SResp 1 cycle after m_SResp.
//  m_SCmdAccept=0 for 10 cycles, 3 requests issued -> REQ_DEPTH=2 holds 2; s_SCmdAccept=0 for the 3rd; m_* stable throughout.
//  MAX_OUTSTANDING=4, 5 back-to-back RDs, no responses -> 5th stalls; outstanding=4; one upstream pop re-enables accept next cycle.
//  WRITERESP_EN=0, 8 WRs -> outstanding stays 0; injected downstream DVA -> err_unexp_resp=1 and stays 1.
//  BYTEEN_EN=0, s_MByteEn=4'b0011 -> m_MByteEn=4'b1111; BYTEEN_EN=1 -> 4'b0011.
//  MReset_n low with 2 reqs + 1 resp buffered -> all outputs at reset values; after release, no stale transfer appears.

Source files
------------

// File: rtl/bus_pipeline_slice.sv
// Buffered register slice between one OCP-style bus master and one slave: FIFOs on the
// request and response paths, a cap on outstanding transactions, and detection of unrequested responses.
module bus_pipeline_slice #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int REQ_DEPTH       = 2,
    parameter int RESP_DEPTH      = 2,
    parameter int MAX_OUTSTANDING = 4,
    parameter int WRITERESP_EN    = 1,
    parameter int BYTEEN_EN       = 0
) (
    input  logic                      Clk,
    input  logic                      MReset_n,
    input  logic [ADDR_WIDTH-1:0]     s_MAddr,
    input  logic [2:0]                s_MCmd,
    input  logic [DATA_WIDTH-1:0]     s_MData,
    input  logic [DATA_WIDTH/8-1:0]   s_MByteEn,
    output logic                      s_SCmdAccept,
    output logic [1:0]                s_SResp,
    output logic [DATA_WIDTH-1:0]     s_SData,
    input  logic                      s_MRespAccept,
    output logic                      m_MReset_n,
    output logic [ADDR_WIDTH-1:0]     m_MAddr,
    output logic [2:0]                m_MCmd,
    output logic [DATA_WIDTH-1:0]     m_MData,
    output logic [DATA_WIDTH/8-1:0]   m_MByteEn,
    input  logic                      m_SCmdAccept,
    input  logic [1:0]                m_SResp,
    input  logic [DATA_WIDTH-1:0]     m_SData,
    output logic                      m_MRespAccept,
    output logic [7:0]                outstanding,
    output logic                      err_unexp_resp
);

    localparam int NB      = DATA_WIDTH / 8;
    localparam int REQ_PW  = $clog2(REQ_DEPTH);
    localparam int RESP_PW = $clog2(RESP_DEPTH);

    localparam logic [2:0] CMD_IDLE  = 3'd0;
    localparam logic [2:0] CMD_WR    = 3'd1;
    localparam logic [2:0] CMD_RD    = 3'd2;
    localparam logic [1:0] RESP_NULL = 2'd0;

    localparam logic [7:0]       MAX_OUT  = 8'(MAX_OUTSTANDING);
    localparam logic [REQ_PW:0]  REQ_ONE  = 1;
    localparam logic [RESP_PW:0] RESP_ONE = 1;

    // A command occupies an outstanding slot only if the slave will answer it.
    function automatic logic expects_resp(input logic [2:0] cmd);
        return (cmd == CMD_RD) || ((WRITERESP_EN != 0) && (cmd == CMD_WR));
    endfunction

    assign m_MReset_n = MReset_n;

    // ------------------------------------------------------------------
    // Request FIFO
    // ------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] req_addr_mem [REQ_DEPTH];
    logic [2:0]            req_cmd_mem  [REQ_DEPTH];
    logic [DATA_WIDTH-1:0] req_data_mem [REQ_DEPTH];

    logic [REQ_PW:0]   req_wr_ptr;
    logic [REQ_PW:0]   req_rd_ptr;
    logic [REQ_PW-1:0] req_wr_idx;
    logic [REQ_PW-1:0] req_rd_idx;
    logic              req_empty;
    logic              req_full;
    logic              req_push;
    logic              req_pop;
    logic [7:0]        out_cnt;

    assign req_wr_idx = req_wr_ptr[REQ_PW-1:0];
    assign req_rd_idx = req_rd_ptr[REQ_PW-1:0];
    assign req_empty  = (req_wr_ptr == req_rd_ptr);
    assign req_full   = (req_wr_ptr[REQ_PW] != req_rd_ptr[REQ_PW]) && (req_wr_idx == req_rd_idx);

    // Accept is a function of registered state only, so a pop never makes room for a same-cycle push.
    assign s_SCmdAccept = MReset_n && !req_full && (out_cnt < MAX_OUT);
    assign req_push     = (s_MCmd != CMD_IDLE) && s_SCmdAccept;
    assign req_pop      = !req_empty && m_SCmdAccept;

    always_ff @(posedge Clk or negedge MReset_n) begin
        if (!MReset_n) begin
            req_wr_ptr <= '0;
            req_rd_ptr <= '0;
        end else begin
            if (req_push) req_wr_ptr <= req_wr_ptr + REQ_ONE;
            if (req_pop)  req_rd_ptr <= req_rd_ptr + REQ_ONE;
        end
    end

    always_ff @(posedge Clk) begin
        if (req_push) begin
            req_addr_mem[req_wr_idx] <= s_MAddr;
            req_cmd_mem[req_wr_idx]  <= s_MCmd;
            req_data_mem[req_wr_idx] <= s_MData;
        end
    end

    assign m_MCmd  = req_empty ? CMD_IDLE : req_cmd_mem[req_rd_idx];
    assign m_MAddr = req_empty ? '0 : req_addr_mem[req_rd_idx];
    assign m_MData = req_empty ? '0 : req_data_mem[req_rd_idx];

    generate
        if (BYTEEN_EN != 0) begin : g_byteen
            logic [NB-1:0] req_be_mem [REQ_DEPTH];

            always_ff @(posedge Clk) begin
                if (req_push) req_be_mem[req_wr_idx] <= s_MByteEn;
            end

            assign m_MByteEn = req_empty ? '0 : req_be_mem[req_rd_idx];
        end else begin : g_no_byteen
            logic be_unused;

            assign be_unused = ^s_MByteEn;
            assign m_MByteEn = '1;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Response FIFO
    // ------------------------------------------------------------------
    logic [1:0]            resp_code_mem [RESP_DEPTH];
    logic [DATA_WIDTH-1:0] resp_data_mem [RESP_DEPTH];

    logic [RESP_PW:0]   resp_wr_ptr;
    logic [RESP_PW:0]   resp_rd_ptr;
    logic [RESP_PW-1:0] resp_wr_idx;
    logic [RESP_PW-1:0] resp_rd_idx;
    logic               resp_empty;
    logic               resp_full;
    logic               resp_push;
    logic               resp_pop;

    assign resp_wr_idx = resp_wr_ptr[RESP_PW-1:0];
    assign resp_rd_idx = resp_rd_ptr[RESP_PW-1:0];
    assign resp_empty  = (resp_wr_ptr == resp_rd_ptr);
    assign resp_full   = (resp_wr_ptr[RESP_PW] != resp_rd_ptr[RESP_PW]) && (resp_wr_idx == resp_rd_idx);

    assign m_MRespAccept = MReset_n && !resp_full;
    assign resp_push     = (m_SResp != RESP_NULL) && m_MRespAccept;
    assign resp_pop      = !resp_empty && s_MRespAccept;

    always_ff @(posedge Clk or negedge MReset_n) begin
        if (!MReset_n) begin
            resp_wr_ptr <= '0;
            resp_rd_ptr <= '0;
        end else begin
            if (resp_push) resp_wr_ptr <= resp_wr_ptr + RESP_ONE;
            if (resp_pop)  resp_rd_ptr <= resp_rd_ptr + RESP_ONE;
        end
    end

    always_ff @(posedge Clk) begin
        if (resp_push) begin
            resp_code_mem[resp_wr_idx] <= m_SResp;
            resp_data_mem[resp_wr_idx] <= m_SData;
        end
    end

    assign s_SResp = resp_empty ? RESP_NULL : resp_code_mem[resp_rd_idx];
    assign s_SData = resp_empty ? '0 : resp_data_mem[resp_rd_idx];

    // ------------------------------------------------------------------
    // Outstanding (upstream view) and pending (downstream view) counters
    // ------------------------------------------------------------------
    logic       out_inc;
    logic       out_dec;
    logic [7:0] pend_cnt;
    logic       pend_inc;
    logic       pend_dec;

    assign out_inc = req_push && expects_resp(s_MCmd);
    assign out_dec = resp_pop && (out_cnt != 8'd0);

    always_ff @(posedge Clk or negedge MReset_n) begin
        if (!MReset_n) begin
            out_cnt <= '0;
        end else if (out_inc && !out_dec) begin
            out_cnt <= out_cnt + 8'd1;
        end else if (out_dec && !out_inc) begin
            out_cnt <= out_cnt - 8'd1;
        end
    end

    assign outstanding = out_cnt;

    // An unrequested response is still buffered and delivered; pending just stays at zero.
    assign pend_inc = req_pop && expects_resp(m_MCmd);
    assign pend_dec = resp_push && (pend_cnt != 8'd0);

    always_ff @(posedge Clk or negedge MReset_n) begin
        if (!MReset_n) begin
            pend_cnt       <= '0;
            err_unexp_resp <= 1'b0;
        end else begin
            if (pend_inc && !pend_dec) begin
                pend_cnt <= pend_cnt + 8'd1;
            end else if (pend_dec && !pend_inc) begin
                pend_cnt <= pend_cnt - 8'd1;
            end
            if (resp_push && (pend_cnt == 8'd0)) begin
                err_unexp_resp <= 1'b1;
            end
        end
    end

endmodule
